// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control sequencer for the 4-bit-opcode accumulator CPU.
// Steps FETCH -> EXEC1 [-> EXEC2] -> FETCH. Holds the instruction register, drives the PC,
// memory and decoder controls, resolves conditional jumps and halts on stp.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   run                 advance enable; 0 freezes state and suppresses strobes
//   mem_rdata           instruction word at the PC, captured in FETCH
//   acc_neg, acc_zero   accumulator flags used by jmi / jeq in EXEC1
//   Q                   one-hot state: FETCH=100, EXEC2=010, EXEC1=001, HALT=000
//   C, operand          opcode and address/immediate fields of the IR
//   ir_load, pc_inc     FETCH strobes
//   pc_load             PC load from operand (jump taken)
//   addr_sel            memory address source: 0=PC, 1=operand
//   mem_wr              memory write strobe (sta)
//   halted              sequencer is in HALT
//   retired             count of completed instructions (wraps)
module cpu_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   acc_neg,
  input  logic                   acc_zero,
  output logic [2:0]             Q,
  output logic [OP_W-1:0]        C,
  output logic [DATA_W-OP_W-1:0] operand,
  output logic                   ir_load,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic                   addr_sel,
  output logic                   mem_wr,
  output logic                   halted,
  output logic [CNT_W-1:0]       retired
);

  localparam logic [OP_W-1:0] OpLda = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OpSta = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OpAdd = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OpSub = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OpJmp = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OpJmi = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OpJeq = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OpStp = OP_W'(4'h7);

  // Encodings double as the one-hot Q output.
  typedef enum logic [2:0] {
    StHalt  = 3'b000,
    StExec1 = 3'b001,
    StExec2 = 3'b010,
    StFetch = 3'b100
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q;
  logic [CNT_W-1:0]  retired_q;

  logic ir_load_raw, pc_inc_raw, pc_load_raw, mem_wr_raw, retire;
  logic strobe_en;

  assign C       = ir_q[DATA_W-1 -: OP_W];
  assign operand = ir_q[DATA_W-OP_W-1:0];

  always_comb begin
    state_d     = state_q;
    ir_load_raw = 1'b0;
    pc_inc_raw  = 1'b0;
    pc_load_raw = 1'b0;
    mem_wr_raw  = 1'b0;
    addr_sel    = 1'b0;
    retire      = 1'b0;
    case (state_q)
      StFetch: begin
        ir_load_raw = 1'b1;
        pc_inc_raw  = 1'b1;
        state_d     = StExec1;
      end
      StExec1: begin
        state_d = StFetch;
        case (C)
          OpLda, OpAdd, OpSub: begin
            addr_sel = 1'b1;
            state_d  = StExec2;
          end
          OpSta: begin
            addr_sel   = 1'b1;
            mem_wr_raw = 1'b1;
          end
          OpJmp:   pc_load_raw = 1'b1;
          OpJmi:   pc_load_raw = acc_neg;
          OpJeq:   pc_load_raw = acc_zero;
          OpStp:   state_d = StHalt;
          default: ;
        endcase
        // Every EXEC1 exit except into EXEC2 completes the instruction, HALT included.
        retire = (state_d != StExec2);
      end
      StExec2: begin
        addr_sel = 1'b1;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;  // unreachable encodings recover
    endcase
  end

  // Strobes only fire on an edge that will actually advance the sequencer.
  assign strobe_en = run & ~reset;
  assign ir_load   = ir_load_raw & strobe_en;
  assign pc_inc    = pc_inc_raw  & strobe_en;
  assign pc_load   = pc_load_raw & strobe_en;
  assign mem_wr    = mem_wr_raw  & strobe_en;

  assign Q       = state_q;
  assign halted  = (state_q == StHalt);
  assign retired = retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      retired_q <= '0;
    end else if (run) begin
      state_q <= state_d;
      if (ir_load_raw) ir_q <= mem_rdata;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer. The driver sets inputs just after each rising edge and
// queues the hand-computed observation for that cycle; the monitor pops and compares on the
// following falling edge.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] mem_rdata;
  logic        acc_neg;
  logic        acc_zero;
  logic [2:0]  Q;
  logic [3:0]  C;
  logic [11:0] operand;
  logic        ir_load, pc_inc, pc_load, addr_sel, mem_wr, halted;
  logic [15:0] retired;

  cpu_sequencer #(.DATA_W(16), .OP_W(4), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .mem_rdata(mem_rdata),
    .acc_neg  (acc_neg),
    .acc_zero (acc_zero),
    .Q        (Q),
    .C        (C),
    .operand  (operand),
    .ir_load  (ir_load),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .addr_sel (addr_sel),
    .mem_wr   (mem_wr),
    .halted   (halted),
    .retired  (retired)
  );

  // {Q, C, operand, ir_load, pc_inc, pc_load, addr_sel, mem_wr, halted, retired}
  typedef logic [40:0] obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t  e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {Q, C, operand, ir_load, pc_inc, pc_load, addr_sel, mem_wr, halted, retired};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got Q=%b C=%h op=%h stb=%b halted=%b retired=%0d, want Q=%b C=%h op=%h stb=%b halted=%b retired=%0d",
                 nm, a[40:38], a[37:34], a[33:22], a[21:17], a[16], a[15:0],
                 e[40:38], e[37:34], e[33:22], e[21:17], e[16], e[15:0]);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [2:0] eq, input logic [3:0] ec,
                          input logic [11:0] eop, input logic [4:0] es, input logic eh,
                          input logic [15:0] er);
    exp_q.push_back({eq, ec, eop, es, eh, er});
    name_q.push_back(nm);
  endtask

  // One cycle: apply inputs after the edge, queue the expected view of this cycle.
  // es = {ir_load, pc_inc, pc_load, addr_sel, mem_wr}
  task automatic cyc(input logic r, input logic rn, input logic [15:0] rd, input logic ng,
                     input logic zr, input string nm, input logic [2:0] eq,
                     input logic [3:0] ec, input logic [11:0] eop, input logic [4:0] es,
                     input logic eh, input logic [15:0] er);
    @(posedge clk);
    #1;
    reset     = r;
    run       = rn;
    mem_rdata = rd;
    acc_neg   = ng;
    acc_zero  = zr;
    push_exp(nm, eq, ec, eop, es, eh, er);
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    mem_rdata = 16'h0000;
    acc_neg   = 1'b0;
    acc_zero  = 1'b0;

    cyc(1, 0, 16'h0000, 0, 0, "reset",        3'b100, 4'h0, 12'h000, 5'b00000, 0, 16'd0);
    // add 5: three cycles
    cyc(0, 1, 16'h2005, 0, 0, "add_fetch",    3'b100, 4'h0, 12'h000, 5'b11000, 0, 16'd0);
    cyc(0, 1, 16'h2005, 0, 0, "add_exec1",    3'b001, 4'h2, 12'h005, 5'b00010, 0, 16'd0);
    cyc(0, 1, 16'h2005, 0, 0, "add_exec2",    3'b010, 4'h2, 12'h005, 5'b00010, 0, 16'd0);
    // sta ABC
    cyc(0, 1, 16'h1ABC, 0, 0, "sta_fetch",    3'b100, 4'h2, 12'h005, 5'b11000, 0, 16'd1);
    cyc(0, 1, 16'h1ABC, 0, 0, "sta_exec1",    3'b001, 4'h1, 12'hABC, 5'b00011, 0, 16'd1);
    // jmi taken / not taken
    cyc(0, 1, 16'h5010, 1, 0, "jmi1_fetch",   3'b100, 4'h1, 12'hABC, 5'b11000, 0, 16'd2);
    cyc(0, 1, 16'h5010, 1, 0, "jmi_taken",    3'b001, 4'h5, 12'h010, 5'b00100, 0, 16'd2);
    cyc(0, 1, 16'h5010, 0, 0, "jmi0_fetch",   3'b100, 4'h5, 12'h010, 5'b11000, 0, 16'd3);
    cyc(0, 1, 16'h5010, 0, 1, "jmi_not",      3'b001, 4'h5, 12'h010, 5'b00000, 0, 16'd3);
    // jeq taken / not taken (acc_neg set on the not-taken case must not matter)
    cyc(0, 1, 16'h6010, 0, 1, "jeq1_fetch",   3'b100, 4'h5, 12'h010, 5'b11000, 0, 16'd4);
    cyc(0, 1, 16'h6010, 0, 1, "jeq_taken",    3'b001, 4'h6, 12'h010, 5'b00100, 0, 16'd4);
    cyc(0, 1, 16'h6010, 1, 0, "jeq0_fetch",   3'b100, 4'h6, 12'h010, 5'b11000, 0, 16'd5);
    cyc(0, 1, 16'h6010, 1, 0, "jeq_not",      3'b001, 4'h6, 12'h010, 5'b00000, 0, 16'd5);
    // NOP
    cyc(0, 1, 16'hF000, 0, 0, "nop_fetch",    3'b100, 4'h6, 12'h010, 5'b11000, 0, 16'd6);
    cyc(0, 1, 16'hF000, 0, 0, "nop_exec1",    3'b001, 4'hF, 12'h000, 5'b00000, 0, 16'd6);
    // lda with run stalled in EXEC2, then in FETCH
    cyc(0, 1, 16'h0123, 0, 0, "lda_fetch",    3'b100, 4'hF, 12'h000, 5'b11000, 0, 16'd7);
    cyc(0, 1, 16'h0123, 0, 0, "lda_exec1",    3'b001, 4'h0, 12'h123, 5'b00010, 0, 16'd7);
    cyc(0, 0, 16'h0123, 0, 0, "stall_e2_a",   3'b010, 4'h0, 12'h123, 5'b00010, 0, 16'd7);
    cyc(0, 0, 16'h0123, 0, 0, "stall_e2_b",   3'b010, 4'h0, 12'h123, 5'b00010, 0, 16'd7);
    cyc(0, 0, 16'h0123, 0, 0, "stall_e2_c",   3'b010, 4'h0, 12'h123, 5'b00010, 0, 16'd7);
    cyc(0, 1, 16'h0123, 0, 0, "lda_exec2",    3'b010, 4'h0, 12'h123, 5'b00010, 0, 16'd7);
    cyc(0, 0, 16'h7000, 0, 0, "stall_fetch",  3'b100, 4'h0, 12'h123, 5'b00000, 0, 16'd8);
    // stp -> HALT
    cyc(0, 1, 16'h7000, 0, 0, "stp_fetch",    3'b100, 4'h0, 12'h123, 5'b11000, 0, 16'd8);
    cyc(0, 1, 16'h2005, 0, 0, "stp_exec1",    3'b001, 4'h7, 12'h000, 5'b00000, 0, 16'd8);
    for (int i = 0; i < 10; i++) begin
      cyc(0, logic'(i % 2), 16'h2005, 1, 1, "halt_hold",
          3'b000, 4'h7, 12'h000, 5'b00000, 1, 16'd9);
    end
    cyc(1, 1, 16'h2345, 0, 0, "halt_reset",   3'b100, 4'h0, 12'h000, 5'b00000, 0, 16'd0);
    // add, then async reset in the middle of the following EXEC1
    cyc(0, 1, 16'h2345, 0, 0, "add2_fetch",   3'b100, 4'h0, 12'h000, 5'b11000, 0, 16'd0);
    cyc(0, 1, 16'h2345, 0, 0, "add2_exec1",   3'b001, 4'h2, 12'h345, 5'b00010, 0, 16'd0);
    cyc(0, 1, 16'h2345, 0, 0, "add2_exec2",   3'b010, 4'h2, 12'h345, 5'b00010, 0, 16'd0);
    cyc(0, 1, 16'h2345, 0, 0, "add3_fetch",   3'b100, 4'h2, 12'h345, 5'b11000, 0, 16'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;  // EXEC1 entered at this edge; no further rising edge before the sample
    push_exp("async_reset", 3'b100, 4'h0, 12'h000, 5'b00000, 0, 16'd0);
    // NOP takes two cycles
    cyc(0, 1, 16'hF000, 0, 0, "nop2_fetch",   3'b100, 4'h0, 12'h000, 5'b11000, 0, 16'd0);
    cyc(0, 1, 16'h2005, 0, 0, "nop2_exec1",   3'b001, 4'hF, 12'h000, 5'b00000, 0, 16'd0);
    cyc(0, 1, 16'h2005, 0, 0, "nop2_done",    3'b100, 4'hF, 12'h000, 5'b11000, 0, 16'd1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Control sequencer for the 4-bit-opcode accumulator CPU.
- Generates the one-hot cycle state Q (FETCH/EXEC1/EXEC2) and the latched opcode C that drive the datapath decoder.
- Owns the instruction register, PC strobes, memory-write and address-select controls, conditional-jump resolution and halt.
- Sits between instruction memory, the PC and the datapath decoder.

Parameters:
- DATA_W, 16, instruction/memory word width.
- OP_W, 4, opcode field width, taken from IR[DATA_W-1 -: OP_W].
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  advance enable; 0 freezes the sequencer.
- mem_rdata  in  DATA_W  instruction word read at the PC, valid during FETCH.
- acc_neg  in  1  accumulator sign bit, sampled in EXEC1.
- acc_zero  in  1  accumulator == 0, sampled in EXEC1.
- Q  out  3  one-hot state: FETCH=100, EXEC2=010, EXEC1=001, HALT=000.
- C  out  OP_W  opcode of the current instruction.
- operand  out  DATA_W-OP_W  address/immediate field of IR.
- ir_load  out  1  IR capture strobe.
- pc_inc  out  1  PC increment strobe.
- pc_load  out  1  PC load from operand (jump taken).
- addr_sel  out  1  memory address source: 0=PC, 1=operand.
- mem_wr  out  1  memory write strobe (sta).
- halted  out  1  sequencer is in HALT.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, any state, mid-instruction included): Q=100, IR=0 (C=0, operand=0), retired=0, halted=0. All strobes are 0 while reset is asserted.
- State register advances only on clk edges with run=1. With run=0, Q/IR/retired hold and all strobes (ir_load, pc_inc, pc_load, mem_wr) are 0. addr_sel still reflects the held state.
- Opcodes:
  - lda 0000, sta 0001, add 0010, sub 0011: memory-operand instructions.
  - jmp 0100, jmi 0101, jeq 0110, stp 0111: control instructions.
  - ldi 1000, lsl 1001: register-only instructions.
  - 1010–1111: NOP.
- FETCH: ir_load=1, pc_inc=1, addr_sel=0. IR <= mem_rdata at the clock edge. Next state EXEC1 always.
- EXEC1: decoding uses the IR latched in FETCH.
  - lda/add/sub: addr_sel=1, next EXEC2.
  - sta: addr_sel=1, mem_wr=1, next FETCH.
  - jmp: pc_load=1. jmi: pc_load=acc_neg. jeq: pc_load=acc_zero. Next FETCH in all three cases.
  - ldi, lsl, NOP: next FETCH.
  - stp: next HALT.
- EXEC2 (lda/add/sub only): addr_sel=1, next FETCH.
- HALT: Q=000, halted=1, all strobes 0. Exits only via reset; run is ignored.
- Cycle counts per instruction: lda/add/sub take 3 cycles; all others take 2. stp takes 2, then HALT.
- Strobes are combinational from the registered state, IR and flags. They are valid in the same cycle and take effect at the ending clock edge.
- retired increments by 1 on each EXEC→FETCH transition and on the EXEC1→HALT transition. It wraps modulo 2^CNT_W.
- Only the four codes listed for Q are legal. Any other state value (unreachable) recovers to FETCH on the next enabled edge.
- pc_inc and pc_load are never both 1. mem_wr is never 1 outside EXEC1.

Test Plan:
- Reset, then run=1, mem_rdata=16'h2005 (add 5) -> Q sequence 100,001,010,100. C=0010 from the first EXEC1. addr_sel=1 in EXEC1/EXEC2. retired=1 after cycle 3.
- mem_rdata=16'h1ABC (sta) -> EXEC1 shows mem_wr=1, addr_sel=1, operand=12'hABC. Q returns to 100 after 2 cycles.
- jmi 16'h5010 with acc_neg=1 -> pc_load=1 in EXEC1. Repeat with acc_neg=0 -> pc_load=0. Same pattern for jeq 16'h6010 with acc_zero.
- stp 16'h7000 -> Q=100,001,000. halted=1 and stays 1 for 10 cycles with run toggling. retired increments once. Reset returns Q=100.
- run=0 held 3 cycles during EXEC2 of lda -> Q stays 010 and all strobes 0. Releasing run completes EXEC2 -> FETCH.
- Assert reset asynchronously mid-EXEC1 (between edges) -> Q=100, C=0, retired=0 immediately, with no clock edge required. Also check NOP opcode 16'hF000 takes 2 cycles.
